// File: rtl/cpu_defs_pkg.sv
// Shared ALU op codes and HI/LO unit state encoding for the execute stage.
package cpu_defs_pkg;

    localparam logic [7:0] ALU_MFHI  = 8'h10;
    localparam logic [7:0] ALU_MTHI  = 8'h11;
    localparam logic [7:0] ALU_MFLO  = 8'h12;
    localparam logic [7:0] ALU_MTLO  = 8'h13;
    localparam logic [7:0] ALU_MULT  = 8'h18;
    localparam logic [7:0] ALU_MULTU = 8'h19;
    localparam logic [7:0] ALU_DIV   = 8'h1A;
    localparam logic [7:0] ALU_DIVU  = 8'h1B;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone,
        StMul1
    } hiloState_e;

endpackage

// File: rtl/hilo_muldiv_div_radix2.sv
// Unsigned restoring divider core, one quotient bit per cycle.
module div_radix2
    import cpu_defs_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DIV_ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int unsigned CntW = $clog2(DIV_ITER + 1);

    logic             busy_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   diff;
    logic             lastStep;

    // quot_q doubles as the dividend shift register; its MSB feeds the partial remainder
    assign remShift = {rem_q, quot_q[WIDTH-1]};
    assign diff     = remShift - {1'b0, divisor_q};
    assign lastStep = busy_q && (cnt_q == CntW'(DIV_ITER - 1));

    assign done = lastStep;
    assign quot = quot_q;
    assign rem  = rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= dividend;
            divisor_q <= divisor;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (!diff[WIDTH]) begin
                rem_q  <= diff[WIDTH-1:0];
                quot_q <= {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q  <= remShift[WIDTH-1:0];
                quot_q <= {quot_q[WIDTH-2:0], 1'b0};
            end
            if (lastStep) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage HI/LO unit: MULT/MULTU, iterative DIV/DIVU, MTHI/MTLO and the HI/LO registers.
// Optional MUL_MULTICYCLE_EN registers the product and writes HI/LO one cycle later.
module hilo_muldiv
    import cpu_defs_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DIV_ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flushE,
    input  logic [7:0]       alucontrolE,
    input  logic             hilowriteE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             stallE,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    hiloState_e         state_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               negQuot_q;
    logic               negRem_q;

    logic               go;
    logic               isDiv;
    logic               isSigned;
    logic               divStart;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [2*WIDTH-1:0] mulA;
    logic [2*WIDTH-1:0] mulB;
    logic [2*WIDTH-1:0] product;
    logic               coreDone;
    logic [WIDTH-1:0]   coreQuot;
    logic [WIDTH-1:0]   coreRem;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;

    assign go       = hilowriteE & ~flushE;
    assign isDiv    = (alucontrolE == ALU_DIV) || (alucontrolE == ALU_DIVU);
    assign isSigned = (alucontrolE == ALU_DIV) || (alucontrolE == ALU_MULT);
    assign divStart = (state_q == StIdle) && go && isDiv;

    assign absA = (isSigned && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign absB = (isSigned && srcbE[WIDTH-1]) ? -srcbE : srcbE;

    // Extending both operands to 2*WIDTH makes the truncated product correct for signed too
    assign mulA    = isSigned ? {{WIDTH{srcaE[WIDTH-1]}}, srcaE} : {{WIDTH{1'b0}}, srcaE};
    assign mulB    = isSigned ? {{WIDTH{srcbE[WIDTH-1]}}, srcbE} : {{WIDTH{1'b0}}, srcbE};
    assign product = mulA * mulB;

    assign quotFix = negQuot_q ? -coreQuot : coreQuot;
    assign remFix  = negRem_q ? -coreRem : coreRem;

    assign hi_o = hi_q;
    assign lo_o = lo_q;

`ifdef MUL_MULTICYCLE_EN
    logic [2*WIDTH-1:0] mulProd_q;
    logic               mulStart;
    assign mulStart = (state_q == StIdle) && go &&
                      ((alucontrolE == ALU_MULT) || (alucontrolE == ALU_MULTU));
`endif

    div_radix2 #(
        .WIDTH    (WIDTH),
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (divStart),
        .abort    (flushE && (state_q == StBusy)),
        .dividend (absA),
        .divisor  (absB),
        .done     (coreDone),
        .quot     (coreQuot),
        .rem      (coreRem)
    );

    always_comb begin
        stallE = 1'b0;
        case (state_q)
`ifdef MUL_MULTICYCLE_EN
            StIdle:  stallE = divStart | mulStart;
`else
            StIdle:  stallE = divStart;
`endif
            StBusy:  stallE = ~flushE;
            default: stallE = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            lo_q      <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
`ifdef MUL_MULTICYCLE_EN
            mulProd_q <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (go) begin
                        case (alucontrolE)
                            ALU_MTHI: hi_q <= srcaE;
                            ALU_MTLO: lo_q <= srcaE;
                            ALU_MULT, ALU_MULTU: begin
`ifdef MUL_MULTICYCLE_EN
                                mulProd_q <= product;
                                state_q   <= StMul1;
`else
                                {hi_q, lo_q} <= product;
`endif
                            end
                            ALU_DIV, ALU_DIVU: begin
                                negQuot_q <= isSigned & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                                negRem_q  <= isSigned & srcaE[WIDTH-1];
                                state_q   <= StBusy;
                            end
                            default: ;
                        endcase
                    end
                end
                StBusy: begin
                    if (flushE) begin
                        state_q <= StIdle;
                    end else if (coreDone) begin
                        state_q <= StDone;
                    end
                end
                // The dividing instruction leaves EX on this edge, so it cannot restart
                StDone: begin
                    state_q <= StIdle;
                    if (!flushE) begin
                        hi_q <= remFix;
                        lo_q <= quotFix;
                    end
                end
                StMul1: begin
                    state_q <= StIdle;
`ifdef MUL_MULTICYCLE_EN
                    if (!flushE) begin
                        {hi_q, lo_q} <= mulProd_q;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: the driver queues hand-computed HI/LO values, the monitor
// compares them one cycle after each instruction leaves EX.
module tb_hilo_muldiv;
    import cpu_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushE;
    logic [7:0]  alucontrolE;
    logic        hilowriteE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        stallE;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t expQ[$];
    int   nVec = 0;
    int   nErr = 0;
    bit   pending = 1'b0;

`ifdef MUL_MULTICYCLE_EN
    localparam int MulStall = 1;
`else
    localparam int MulStall = 0;
`endif
    localparam int DivStall = 33;

    always #5 clk = ~clk;

    hilo_muldiv #(
        .WIDTH    (32),
        .DIV_ITER (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flushE      (flushE),
        .alucontrolE (alucontrolE),
        .hilowriteE  (hilowriteE),
        .srcaE       (srcaE),
        .srcbE       (srcbE),
        .stallE      (stallE),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nVec++;
        if (act !== req) begin
            nErr++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Drive one instruction and hold it in EX until the unit stops stalling
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo,
                         input int expStall, input string name);
        int stalls = 0;
        int cycles = 0;
        expQ.push_back('{name, expHi, expLo});
        alucontrolE = op;
        srcaE       = a;
        srcbE       = b;
        hilowriteE  = 1'b1;
        flushE      = 1'b0;
        do begin
            @(negedge clk);
            cycles++;
            if (stallE) begin
                stalls++;
                // operands are latched at start; scramble them while the divider runs
                if (cycles >= 2) begin
                    srcaE = $urandom;
                    srcbE = $urandom;
                end
            end
        end while (stallE && cycles < 200);
        check({name, "_stall"}, 32'(stalls), 32'(expStall));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hilowriteE  = 1'b0;
        flushE      = 1'b0;
        alucontrolE = 8'h00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                nVec++;
                if (expQ.size() == 0) begin
                    nErr++;
                    $display("FAIL unexpected_retire: got hi=%08h lo=%08h expected none",
                             hi_o, lo_o);
                end else begin
                    e = expQ.pop_front();
                    if (hi_o !== e.hi || lo_o !== e.lo) begin
                        nErr++;
                        $display("FAIL %s: got hi=%08h lo=%08h expected hi=%08h lo=%08h",
                                 e.name, hi_o, lo_o, e.hi, e.lo);
                    end
                end
            end
            if (!rst && hilowriteE && (!stallE || flushE)) begin
                pending = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst         = 1'b1;
        flushE      = 1'b0;
        alucontrolE = 8'h00;
        hilowriteE  = 1'b0;
        srcaE       = '0;
        srcbE       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_hi", hi_o, 32'h0);
        check("reset_lo", lo_o, 32'h0);
        check("reset_stall", {31'b0, stallE}, 32'h0);
        @(posedge clk);
        #1;

        issue(ALU_MTHI, 32'h12345678, 32'h0, 32'h12345678, 32'h00000000, 0, "mthi");
        issue(ALU_MTLO, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0, "mtlo");
        issue(ALU_MFHI, 32'hDEADBEEF, 32'h1, 32'h12345678, 32'h9ABCDEF0, 0, "mfhi_nowrite");

        // flushed MTHI must not write
        expQ.push_back('{"mthi_flushed", 32'h12345678, 32'h9ABCDEF0});
        alucontrolE = ALU_MTHI;
        srcaE       = 32'hCAFEF00D;
        hilowriteE  = 1'b1;
        flushE      = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;

        issue(ALU_MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, MulStall, "mult_neg");
        issue(ALU_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, MulStall, "multu");
        issue(ALU_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DivStall, "div_m7_2");
        issue(ALU_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DivStall,
              "div_7_m2");
        issue(ALU_DIVU, 32'd100, 32'h0, 32'h00000064, 32'hFFFFFFFF, DivStall, "divu_by0");
        issue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DivStall,
              "div_ovf");
        issue(ALU_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'h00000001, DivStall, "div_m7_by0");
        issue(ALU_DIVU, 32'd1000, 32'd7, 32'h00000006, 32'h0000008E, DivStall, "divu_1000_7");

        // flush a running divide at cycle 10: HI/LO keep 6/142
        expQ.push_back('{"div_flushed", 32'h00000006, 32'h0000008E});
        alucontrolE = ALU_DIV;
        srcaE       = 32'd500;
        srcbE       = 32'd3;
        hilowriteE  = 1'b1;
        flushE      = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flushE = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        flushE     = 1'b0;
        hilowriteE = 1'b0;
        @(negedge clk);
        check("flush_stall_clear", {31'b0, stallE}, 32'h0);
        @(posedge clk);
        #1;

        // reset at cycle 5 of a divide
        alucontrolE = ALU_DIVU;
        srcaE       = 32'd77;
        srcbE       = 32'd5;
        hilowriteE  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst        = 1'b1;
        hilowriteE = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_hi", hi_o, 32'h0);
        check("midrst_lo", lo_o, 32'h0);
        check("midrst_stall", {31'b0, stallE}, 32'h0);
        @(posedge clk);
        #1;

        // back-to-back: divide then multiply, no restart in DONE
        issue(ALU_DIVU, 32'd9, 32'd4, 32'h00000001, 32'h00000002, DivStall, "divu_9_4");
        issue(ALU_MULT, 32'd3, 32'd5, 32'h00000000, 32'h0000000F, MulStall, "mult_3_5");
        hilowriteE  = 1'b0;
        alucontrolE = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_restart", {31'b0, stallE}, 32'h0);
        end
        check("final_hi", hi_o, 32'h0);
        check("final_lo", lo_o, 32'h0000000F);
        idle(2);
        check("scoreboard_drained", 32'(expQ.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
